// File: rtl/wb_rr_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS masters.
// Holds the grant for a whole CYC and aborts stalled strobes with ERR after a timeout.
module wb_rr_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [DATA_WIDTH/8-1:0]           s_sel_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              timeout_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT, ST_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [15:0]             timer_q, timer_d;

  logic [IDX_W-1:0]        winner;
  logic                    found;
  logic                    route_en;

  logic [SEL_WIDTH-1:0]    sel_arr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]   adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   dat_arr [NUM_MASTERS];

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (int'(v) == NUM_MASTERS - 1) return '0;
    return v + 1'b1;
  endfunction

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_slices
    assign sel_arr[k] = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
    assign adr_arr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign m_dat_o[k*DATA_WIDTH +: DATA_WIDTH] = (route_en && grant_q[k]) ? s_dat_i : '0;
  end

  // Response routing only while BUSY; late slave responses during DRAIN are swallowed.
  assign route_en = (state_q == ST_BUSY);
  assign m_ack_o  = route_en ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o  = route_en            ? (grant_q & {NUM_MASTERS{s_err_i}}) :
                    (state_q == ST_ABORT) ? grant_q : '0;
  assign grant_o  = grant_q;

  // First requester at or above the round-robin pointer, with wrap.
  always_comb begin
    int          cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NUM_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!found && m_cyc_i[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // NOTE: every output and next-state value is defaulted first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    timeout_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (found) begin
          state_d = ST_BUSY;
          owner_d = winner;
          grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
        end
      end
      ST_BUSY: begin
        s_cyc_o = m_cyc_i[owner_q];
        s_stb_o = m_stb_i[owner_q];
        s_we_o  = m_we_i[owner_q];
        s_sel_o = sel_arr[owner_q];
        s_adr_o = adr_arr[owner_q];
        s_dat_o = dat_arr[owner_q];
        if (!m_cyc_i[owner_q]) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_inc(owner_q);
          timer_d  = '0;
        end else if (s_ack_i || s_err_i || !m_stb_i[owner_q]) begin
          timer_d = '0;
        end else begin
          timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
          if (timer_d == TIMEOUT_VAL) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        timeout_o = 1'b1;
        timer_d   = '0;
        state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!m_cyc_i[owner_q]) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_inc(owner_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
    end
  end

endmodule
